// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and output-mode encoding for the flagged sync FIFO.
package sync_fifo_pkg;

  // Output mode encoding for the FWFT parameter.
  localparam int FWFT_OFF = 0;  // registered read, 1-cycle latency
  localparam int FWFT_ON  = 1;  // first-word-fall-through

  // Ceiling log2, evaluated at elaboration time.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer width: a single-bit pointer is still needed when DEPTH <= 2.
  function automatic int ptr_width(input int depth);
    int w;
    w = ceil_log2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return ceil_log2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer. Wraps explicitly at DEPTH-1 so non-power-of-two
// depths never produce an out-of-range index.
module fifo_ptr_wrap
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 7,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Advance on inc, folding DEPTH-1 back to 0.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, watermark flags and sticky
// overflow/underflow. FWFT selects registered or fall-through output.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 7,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = FWFT_OFF,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_TH   = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc;

  // Flags are pure decodes of the registered count.
  assign full         = (count == CNT_MAX);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // A read on a full FIFO frees the slot the concurrent write needs.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Storage: written only on an accepted write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

  // Occupancy: +1 write only, -1 read only, unchanged otherwise.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc) overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd_en & empty)   underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is always presented; rd_en pops it.
      assign data_out   = mem[rd_ptr];
      assign data_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // Registered read: one-cycle valid pulse per accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc)
            data_q <= mem[rd_ptr];
        end
      end

      assign data_out   = data_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule
